// File: rtl/regfile_mp.sv
// regfile_mp: multi-port integer register file for riscvnano.
// NREAD combinational read ports, NWRITE prioritised write ports, optional
// write-to-read bypass, hardwired-zero x0, and a clear sequencer that zeroes
// the whole array after reset or on clear_req.
module regfile_mp #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NREAD  = 2,
    parameter int NWRITE = 1,
    parameter int BYPASS = 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              clear_req,
    output logic                              ready,
    input  logic [NREAD*$clog2(NREGS)-1:0]    raddr,
    output logic [NREAD*XLEN-1:0]             rdata,
    input  logic [NWRITE-1:0]                 we,
    input  logic [NWRITE*$clog2(NREGS)-1:0]   waddr,
    input  logic [NWRITE*XLEN-1:0]            wdata
);

    localparam int AW = $clog2(NREGS);
    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   idx_q, idx_d;

    // Storage; contents are only ever initialised by the clear sequencer.
    logic [XLEN-1:0] mem_q [NREGS];

    // Unpacked views of the packed write ports.
    logic [AW-1:0]   waddr_w [NWRITE];
    logic [XLEN-1:0] wdata_w [NWRITE];

    for (genvar j = 0; j < NWRITE; j++) begin : g_wport
        assign waddr_w[j] = waddr[j*AW +: AW];
        assign wdata_w[j] = wdata[j*XLEN +: XLEN];
    end

    // Control state: sequencer state and clear index, reset asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLEAR;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state logic: walk the index through every entry, restart on clear_req.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            CLEAR: begin
                if (clear_req) begin
                    idx_d = '0;
                end else if (idx_q == LAST_IDX) begin
                    state_d = RUN;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            RUN: begin
                if (clear_req) begin
                    state_d = CLEAR;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = CLEAR;
                idx_d   = '0;
            end
        endcase
    end

    assign ready = (state_q == RUN);

    // Array update: clear one entry per cycle, otherwise apply writes in port
    // order so the highest-numbered port lands last and wins a conflict.
    always_ff @(posedge clk) begin
        if (state_q == CLEAR) begin
            mem_q[idx_q] <= '0;
        end else begin
            for (int j = 0; j < NWRITE; j++) begin
                if (we[j] && (waddr_w[j] != '0)) begin
                    mem_q[waddr_w[j]] <= wdata_w[j];
                end
            end
        end
    end

    // Combinational reads: x0 and the clearing array read zero; a matching
    // in-flight write overrides the stored value when bypass is enabled.
    always_comb begin
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] val;
        rdata = '0;
        for (int i = 0; i < NREAD; i++) begin
            ra  = raddr[i*AW +: AW];
            val = '0;
            if (ready && (ra != '0)) begin
                val = mem_q[ra];
                if (BYPASS != 0) begin
                    for (int j = 0; j < NWRITE; j++) begin
                        if (we[j] && (waddr_w[j] == ra)) begin
                            val = wdata_w[j];
                        end
                    end
                end
            end
            rdata[i*XLEN +: XLEN] = val;
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard bench for regfile_mp. Two instances run in
// lockstep: a 2-read/2-write bypassing file and a 1-read/1-write
// non-bypassing file. Stimulus pushes expected values into a queue; a
// monitor drains and compares it on every falling edge.
module tb_regfile_mp;

    localparam int K_RD0  = 0;
    localparam int K_RD1  = 1;
    localparam int K_ARD  = 2;
    localparam int K_MRDY = 3;
    localparam int K_ARDY = 4;

    logic        clk;
    logic        rst_n;
    logic        clear_req;

    logic        m_ready;
    logic [9:0]  m_raddr;
    logic [63:0] m_rdata;
    logic [1:0]  m_we;
    logic [9:0]  m_waddr;
    logic [63:0] m_wdata;

    logic        a_ready;
    logic [4:0]  a_raddr;
    logic [31:0] a_rdata;
    logic [0:0]  a_we;
    logic [4:0]  a_waddr;
    logic [31:0] a_wdata;

    int          ntests;
    int          nfail;

    int          q_kind [$];
    logic [31:0] q_exp  [$];
    string       q_name [$];

    regfile_mp #(.XLEN(32), .NREGS(32), .NREAD(2), .NWRITE(2), .BYPASS(1)) u_main (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_req (clear_req),
        .ready     (m_ready),
        .raddr     (m_raddr),
        .rdata     (m_rdata),
        .we        (m_we),
        .waddr     (m_waddr),
        .wdata     (m_wdata)
    );

    regfile_mp #(.XLEN(32), .NREGS(32), .NREAD(1), .NWRITE(1), .BYPASS(0)) u_alt (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_req (clear_req),
        .ready     (a_ready),
        .raddr     (a_raddr),
        .rdata     (a_rdata),
        .we        (a_we),
        .waddr     (a_waddr),
        .wdata     (a_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", ntests);
        $fatal(1, "watchdog");
    end

    // Monitor: compare every queued expectation against the live outputs.
    always @(negedge clk) begin
        while (q_kind.size() != 0) begin
            int          k;
            logic [31:0] e;
            logic [31:0] act;
            string       nm;
            k   = q_kind.pop_front();
            e   = q_exp.pop_front();
            nm  = q_name.pop_front();
            case (k)
                K_RD0:   act = m_rdata[31:0];
                K_RD1:   act = m_rdata[63:32];
                K_ARD:   act = a_rdata;
                K_MRDY:  act = {31'd0, m_ready};
                default: act = {31'd0, a_ready};
            endcase
            ntests = ntests + 1;
            if (act !== e) begin
                nfail = nfail + 1;
                $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, e, $time);
            end
        end
    end

    task automatic chk(input int kind, input logic [31:0] v, input string nm);
        q_kind.push_back(kind);
        q_exp.push_back(v);
        q_name.push_back(nm);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        m_we    = '0;
        m_waddr = '0;
        m_wdata = '0;
        a_we    = '0;
        a_waddr = '0;
        a_wdata = '0;
    endtask

    // Follow a clear for n cycles; junk writes aimed at already-cleared
    // entries must not stick, reads must be zero, ready rises only at the end.
    task automatic clear_window(input int n, input bit fin);
        for (int k = 1; k <= n; k++) begin
            bit last;
            step();
            clear_req = 1'b0;
            last = fin && (k == n);
            if (k >= 3 && !last) begin
                m_we    = 2'b11;
                m_waddr = {5'd2, 5'd1};
                m_wdata = {32'hBAD0_0002, 32'hBAD0_0001};
                a_we    = 1'b1;
                a_waddr = 5'd1;
                a_wdata = 32'hBAD0_0003;
            end else begin
                idle();
            end
            m_raddr = {5'd2, 5'd1};
            a_raddr = 5'd1;
            chk(K_MRDY, last ? 32'd1 : 32'd0, "clear_ready_main");
            chk(K_ARDY, last ? 32'd1 : 32'd0, "clear_ready_alt");
            chk(K_RD0, 32'd0, "clear_rd0");
            chk(K_RD1, 32'd0, "clear_rd1");
            chk(K_ARD, 32'd0, "clear_alt_rd");
        end
    endtask

    task automatic pulse_clear(input logic [31:0] rdy_now);
        step();
        clear_req = 1'b1;
        m_we      = 2'b01;
        m_waddr   = {5'd0, 5'd2};
        m_wdata   = {32'd0, 32'h0000_0BAD};
        a_we      = 1'b0;
        chk(K_MRDY, rdy_now, "pulse_ready");
    endtask

    task automatic readall_zero();
        for (int i = 0; i < 32; i++) begin
            step();
            idle();
            m_raddr = {5'(31 - i), 5'(i)};
            a_raddr = 5'(i);
            chk(K_RD0, 32'd0, "zero_rd0");
            chk(K_RD1, 32'd0, "zero_rd1");
            chk(K_ARD, 32'd0, "zero_alt");
        end
    endtask

    initial begin
        ntests    = 0;
        nfail     = 0;
        rst_n     = 1'b0;
        clear_req = 1'b0;
        m_raddr   = '0;
        a_raddr   = '0;
        idle();

        // Held in reset: not ready.
        for (int i = 0; i < 3; i++) begin
            step();
            chk(K_MRDY, 32'd0, "reset_ready_main");
            chk(K_ARDY, 32'd0, "reset_ready_alt");
        end
        rst_n = 1'b1;
        clear_window(32, 1'b1);
        readall_zero();

        // x5 write: bypassed on main, old value on alt, stored next cycle.
        step();
        m_we = 2'b01; m_waddr = {5'd0, 5'd5}; m_wdata = {32'd0, 32'hDEAD_BEEF};
        a_we = 1'b1;  a_waddr = 5'd5;         a_wdata = 32'hDEAD_BEEF;
        m_raddr = {5'd0, 5'd5}; a_raddr = 5'd5;
        chk(K_RD0, 32'hDEAD_BEEF, "x5_bypass_main");
        chk(K_ARD, 32'h0, "x5_nobypass_alt");
        step();
        idle();
        chk(K_RD0, 32'hDEAD_BEEF, "x5_stored_main");
        chk(K_ARD, 32'hDEAD_BEEF, "x5_stored_alt");

        // x0 write is dropped and never bypassed.
        step();
        m_we = 2'b01; m_waddr = {5'd0, 5'd0}; m_wdata = {32'd0, 32'h1};
        a_we = 1'b1;  a_waddr = 5'd0;         a_wdata = 32'h1;
        m_raddr = {5'd0, 5'd0}; a_raddr = 5'd0;
        chk(K_RD0, 32'h0, "x0_bypass_main");
        chk(K_ARD, 32'h0, "x0_alt");
        step();
        idle();
        chk(K_RD0, 32'h0, "x0_stored_main");
        chk(K_ARD, 32'h0, "x0_stored_alt");

        // x7: bypass shows new data, non-bypass shows previous contents.
        step();
        m_we = 2'b01; m_waddr = {5'd0, 5'd7}; m_wdata = {32'd0, 32'h1234_5678};
        a_we = 1'b1;  a_waddr = 5'd7;         a_wdata = 32'h1234_5678;
        m_raddr = {5'd0, 5'd7}; a_raddr = 5'd7;
        chk(K_RD0, 32'h1234_5678, "x7_first_main");
        chk(K_ARD, 32'h0, "x7_first_alt");
        step();
        m_wdata = {32'd0, 32'hA5A5_A5A5};
        a_wdata = 32'hA5A5_A5A5;
        chk(K_RD0, 32'hA5A5_A5A5, "x7_bypass_main");
        chk(K_ARD, 32'h1234_5678, "x7_prev_alt");
        step();
        idle();
        chk(K_RD0, 32'hA5A5_A5A5, "x7_stored_main");
        chk(K_ARD, 32'hA5A5_A5A5, "x7_stored_alt");

        // Two ports to x3: port 1 wins, in bypass and in storage.
        step();
        m_we = 2'b11; m_waddr = {5'd3, 5'd3}; m_wdata = {32'h22, 32'h11};
        m_raddr = {5'd3, 5'd3};
        chk(K_RD0, 32'h22, "x3_conflict_bypass0");
        chk(K_RD1, 32'h22, "x3_conflict_bypass1");
        step();
        idle();
        chk(K_RD0, 32'h22, "x3_conflict_stored");

        // Two ports to distinct addresses.
        step();
        m_we = 2'b11; m_waddr = {5'd6, 5'd4}; m_wdata = {32'h66, 32'h44};
        m_raddr = {5'd6, 5'd4};
        chk(K_RD0, 32'h44, "x4_dual_bypass");
        chk(K_RD1, 32'h66, "x6_dual_bypass");
        step();
        idle();
        m_raddr = {5'd4, 5'd6};
        chk(K_RD0, 32'h66, "x6_dual_stored");
        chk(K_RD1, 32'h44, "x4_dual_stored");

        // Port 1 aimed at x0 must not disturb port 0 or read as non-zero.
        step();
        m_we = 2'b11; m_waddr = {5'd0, 5'd9}; m_wdata = {32'hFF, 32'h99};
        m_raddr = {5'd0, 5'd9};
        chk(K_RD0, 32'h99, "x9_bypass");
        chk(K_RD1, 32'h0, "x0_port1_bypass");
        step();
        idle();
        chk(K_RD0, 32'h99, "x9_stored");
        chk(K_RD1, 32'h0, "x0_port1_stored");

        // Fill x1..x31, read them all back.
        for (int i = 1; i < 32; i++) begin
            step();
            m_we = 2'b01; m_waddr = {5'd0, 5'(i)}; m_wdata = {32'd0, 32'h1000 + 32'(i)};
            a_we = 1'b1;  a_waddr = 5'(i);         a_wdata = 32'h2000 + 32'(i);
            m_raddr = {5'd0, 5'(i)};
            chk(K_RD0, 32'h1000 + 32'(i), "fill_bypass");
        end
        for (int i = 1; i < 32; i++) begin
            step();
            idle();
            m_raddr = {5'(32 - i), 5'(i)};
            a_raddr = 5'(i);
            chk(K_RD0, 32'h1000 + 32'(i), "fill_rd0");
            chk(K_RD1, 32'h1000 + 32'(32 - i), "fill_rd1");
            chk(K_ARD, 32'h2000 + 32'(i), "fill_alt");
        end

        // clear_req from RUN: 32 cycles not ready, then everything reads zero.
        pulse_clear(32'd1);
        clear_window(33, 1'b1);
        readall_zero();

        // clear_req mid-clear restarts the sequence from index 0.
        step();
        m_we = 2'b01; m_waddr = {5'd0, 5'd8}; m_wdata = {32'd0, 32'h88};
        pulse_clear(32'd1);
        clear_window(10, 1'b0);
        pulse_clear(32'd0);
        clear_window(33, 1'b1);
        readall_zero();

        // Refill a few entries, then reset at clear index 10.
        for (int i = 1; i < 32; i++) begin
            step();
            m_we = 2'b01; m_waddr = {5'd0, 5'(i)}; m_wdata = {32'd0, 32'h3000 + 32'(i)};
            a_we = 1'b1;  a_waddr = 5'(i);         a_wdata = 32'h4000 + 32'(i);
        end
        pulse_clear(32'd1);
        clear_window(11, 1'b0);
        #1;
        rst_n = 1'b0;
        chk(K_MRDY, 32'd0, "midclear_reset_ready");
        step();
        step();
        rst_n = 1'b1;
        clear_window(32, 1'b1);
        readall_zero();

        // Reset asserted in RUN drops ready without waiting for a clock edge.
        step();
        rst_n = 1'b0;
        #1;
        ntests = ntests + 1;
        if (m_ready !== 1'b0 || a_ready !== 1'b0) begin
            nfail = nfail + 1;
            $display("FAIL async_reset_direct: m_ready=%b a_ready=%b (t=%0t)", m_ready, a_ready, $time);
        end
        chk(K_MRDY, 32'd0, "async_reset_ready_main");
        chk(K_ARDY, 32'd0, "async_reset_ready_alt");
        step();
        rst_n = 1'b1;
        clear_window(32, 1'b1);

        step();
        step();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        if (ntests < 12) begin
            $display("FAIL too few tests executed: %0d", ntests);
        end
        if (nfail != 0) begin
            $display("FAIL %0d of %0d tests failed", nfail, ntests);
        end else begin
            $display("PASS all %0d tests passed", ntests);
        end
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file for the riscvnano core, successor to the single-write, dual-read register file. It provides NREAD combinational read ports, NWRITE synchronous write ports with fixed priority, optional same-cycle write-to-read bypass, a hardwired-zero x0, and a hardware clear sequencer that zeroes every entry after reset or on request. It sits between decode (read addresses) and writeback (write ports).

## Interface
- XLEN, 32, data width in bits.
- NREGS, 32, number of entries; power of two, at least 2. AW = log2(NREGS) is derived internally.
- NREAD, 2, number of read ports, at least 1.
- NWRITE, 1, number of write ports, 1 to 4.
- BYPASS, 1, 1 = a same-cycle write is visible on the read ports; 0 = reads return stored contents only.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- clear_req  in  1  single-cycle pulse; restarts the clear sequence.
- ready  out  1  high when the array is initialised and accepting writes.
- raddr  in  NREAD*AW  read addresses; port i uses bits [i*AW +: AW].
- rdata  out  NREAD*XLEN  read data; port i uses bits [i*XLEN +: XLEN].
- we  in  NWRITE  per-port write enable.
- waddr  in  NWRITE*AW  write addresses, packed the same way as raddr.
- wdata  in  NWRITE*XLEN  write data, packed the same way as rdata.

## Operation
- FSM has two states: CLEAR and RUN.
- Reset (rst_n low): state = CLEAR, clear index = 0, ready = 0. Array contents are not reset directly.
- CLEAR state:
  - Each cycle writes 0 to entry[index], then increments index.
  - When index = NREGS-1, the write is performed and state goes to RUN.
  - we is ignored for the whole of CLEAR.
  - All rdata read 0.
- RUN state:
  - ready = 1.
  - For each port j with we[j]=1 and waddr[j] != 0, entry[waddr[j]] takes wdata[j] at the clock edge.
- Write conflict: when several enabled ports target the same address, the highest-numbered port wins.
- clear_req:
  - In RUN: next state is CLEAR with index 0, and ready falls on the next cycle.
  - In CLEAR: index restarts at 0.
  - Any write presented in the same cycle as clear_req in RUN is still performed, but the clear then zeroes it.
- Reads (RUN) are combinational:
  - raddr = 0 gives 0.
  - Otherwise, if BYPASS=1 and some port has we=1 with a matching waddr, rdata is the wdata of the highest-numbered such port.
  - Otherwise rdata is the stored entry.
- Writes to address 0 are dropped and never bypassed.
- Entry 0 is never written with a non-zero value.

## Timing
- Read latency is 0 cycles (combinational from raddr, we, waddr and wdata).
- Write latency is 1 cycle. Without bypass, data is visible on the cycle after the edge.
- Clear duration is exactly NREGS cycles.
  - ready goes high on the NREGS-th rising edge after rst_n deasserts; this is the edge that completes the entry[NREGS-1] write.
  - After clear_req in RUN, ready is low for exactly NREGS cycles.
- rst_n assertion at any point, including mid-clear, immediately forces ready = 0 and index = 0.
- Reset deassertion is synchronised externally.
- Outputs are held while clear_req is held high: index stays at 0 and ready stays 0.

## Test plan
- Reset release with NREGS=32 -> ready=0 for 32 cycles, then ready=1. Every raddr reads 0x00000000.
- RUN: write 0xDEADBEEF to x5 -> the next cycle raddr=5 reads 0xDEADBEEF. Write 0x1 to x0 -> raddr=0 still reads 0.
- BYPASS=1: we[0]=1, waddr=7, wdata=0xA5A5A5A5, raddr=7 in the same cycle -> rdata=0xA5A5A5A5. With BYPASS=0 -> rdata is the previous value of x7.
- NWRITE=2, both ports write x3 (port0=0x11, port1=0x22) -> x3=0x22. A same-cycle bypass read of x3 also returns 0x22.
- Fill x1..x31 with non-zero values, pulse clear_req -> ready low for 32 cycles, writes during that window are ignored, then all entries read 0.
- rst_n asserted at clear index 10 -> ready=0 immediately. After release, a full 32-cycle clear runs again.
